// File: rtl/snn_enc_pkg.sv
// Shared types and constants for the spike-time encoder.
// Macro SPIKE_ENC_DBUF_EN (see spike_train_encoder) selects double buffering.
`ifndef SNN_NUM_SPIKES
`define SNN_NUM_SPIKES 4
`endif
`ifndef SNN_TIME_PERIOD
`define SNN_TIME_PERIOD 8
`endif
`ifndef SNN_LOG_TIME_PERIOD
`define SNN_LOG_TIME_PERIOD 3
`endif

package snn_enc_pkg;

  localparam int unsigned NUM_SPIKES_DEF      = `SNN_NUM_SPIKES;
  localparam int unsigned TIME_PERIOD_DEF     = `SNN_TIME_PERIOD;
  localparam int unsigned LOG_TIME_PERIOD_DEF = `SNN_LOG_TIME_PERIOD;
  localparam int unsigned PIX_BITS_DEF        = 8;

  // Right shift that maps an inverted pixel onto the frame time range
  localparam int unsigned ENC_SHIFT = PIX_BITS_DEF - LOG_TIME_PERIOD_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } enc_state_t;

  typedef logic [LOG_TIME_PERIOD_DEF:0] spike_time_t;

  // MSB set marks "no spike in this frame"
  localparam spike_time_t NO_SPIKE = {1'b1, {LOG_TIME_PERIOD_DEF{1'b0}}};

endpackage

// File: rtl/spike_train_encoder_intensity_to_spike_time.sv
// Combinational pixel-to-spike-time conversion; brighter pixels spike earlier.
module intensity_to_spike_time #(
  parameter int unsigned PIX_BITS        = 8,
  parameter int unsigned LOG_TIME_PERIOD = 3,
  parameter int unsigned THRESH          = 16
) (
  input  logic [PIX_BITS-1:0]      pix,
  output logic [LOG_TIME_PERIOD:0] spike_time
);

  localparam int unsigned SHIFT = PIX_BITS - LOG_TIME_PERIOD;

  logic [PIX_BITS-1:0] inv;

  // Invert (max - pix), scale to the frame range, suppress dim pixels
  always_comb begin
    inv = ~pix;
    if (pix < PIX_BITS'(THRESH)) begin
      spike_time = {1'b1, {LOG_TIME_PERIOD{1'b0}}};
    end else begin
      spike_time = {1'b0, LOG_TIME_PERIOD'(inv >> SHIFT)};
    end
  end

endmodule

// File: rtl/spike_train_encoder.sv
// Pixel stream to temporally coded spike volley, with a sweeping frame time.
// Define SPIKE_ENC_DBUF_EN to let loading of the next frame overlap RUN.
module spike_train_encoder
  import snn_enc_pkg::*;
#(
  parameter int unsigned NUM_SPIKES      = `SNN_NUM_SPIKES,
  parameter int unsigned TIME_PERIOD     = `SNN_TIME_PERIOD,
  parameter int unsigned LOG_TIME_PERIOD = `SNN_LOG_TIME_PERIOD,
  parameter int unsigned PIX_BITS        = 8,
  parameter int unsigned THRESH          = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        enable,
  input  logic                                        train_en,
  input  logic                                        pix_valid,
  input  logic [PIX_BITS-1:0]                         pix_data,
  output logic                                        pix_ready,
  output logic [LOG_TIME_PERIOD:0]                    time_val,
  output logic [NUM_SPIKES-1:0][LOG_TIME_PERIOD:0]    spike_times,
  output logic                                        training,
  output logic                                        frame_done,
  output logic                                        busy
);

  localparam int unsigned IDX_W = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;
  localparam int unsigned TV_W  = LOG_TIME_PERIOD + 1;
  localparam logic [TV_W-1:0]  T_LAST   = TV_W'(TIME_PERIOD - 1);
  localparam logic [TV_W-1:0]  T_PRE    = TV_W'(TIME_PERIOD - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SPIKES - 1);
  localparam logic [TV_W-1:0]  NO_SPK   = {1'b1, {LOG_TIME_PERIOD{1'b0}}};

  enc_state_t                              state;
  logic [IDX_W-1:0]                        ld_idx;
  logic                                    load_full;
  logic [NUM_SPIKES-1:0][LOG_TIME_PERIOD:0] load_buf;
  logic [LOG_TIME_PERIOD:0]                enc;
  logic                                    accept;
  logic                                    last_cycle;
  logic                                    start;

  intensity_to_spike_time #(
    .PIX_BITS        (PIX_BITS),
    .LOG_TIME_PERIOD (LOG_TIME_PERIOD),
    .THRESH          (THRESH)
  ) u_enc (
    .pix        (pix_data),
    .spike_time (enc)
  );

`ifdef SPIKE_ENC_DBUF_EN
  assign pix_ready = !load_full;
`else
  assign pix_ready = !load_full && (state == IDLE);
`endif

  assign accept     = pix_valid && pix_ready;
  assign last_cycle = (state == RUN) && (time_val == T_LAST);
  assign start      = load_full && enable && ((state == IDLE) || last_cycle);

  // Load buffer: fill slots in arrival order, flag full after the last slot
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_idx    <= '0;
      load_full <= 1'b0;
      load_buf  <= {NUM_SPIKES{NO_SPK}};
    end else begin
      if (start) begin
        load_full <= 1'b0;
      end
      if (accept) begin
        load_buf[ld_idx] <= enc;
        if (ld_idx == IDX_LAST) begin
          ld_idx    <= '0;
          load_full <= 1'b1;
        end else begin
          ld_idx <= ld_idx + IDX_W'(1);
        end
      end
    end
  end

  // Frame FSM: IDLE parks the layer at end-of-period, RUN sweeps time_val
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      time_val    <= T_LAST;
      spike_times <= {NUM_SPIKES{NO_SPK}};
      training    <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_done <= (state == RUN) && (time_val == T_PRE);
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            time_val    <= '0;
            spike_times <= load_buf;
            training    <= train_en;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          if (start) begin
            time_val    <= '0;
            spike_times <= load_buf;
            training    <= train_en;
          end else if (last_cycle) begin
            state       <= IDLE;
            time_val    <= T_LAST;
            spike_times <= {NUM_SPIKES{NO_SPK}};
            training    <= 1'b0;
            busy        <= 1'b0;
          end else begin
            time_val <= time_val + TV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_train_encoder.sv
// Self-checking bench for spike_train_encoder (NUM_SPIKES=4, TIME_PERIOD=8).
module tb_spike_train_encoder;

  localparam int NS  = 4;
  localparam int TP  = 8;
  localparam int LTP = 3;
  localparam int PB  = 8;
  localparam int TH  = 16;
  localparam int NO  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             train_en = 1'b0;
  logic             pix_valid = 1'b0;
  logic [PB-1:0]    pix_data = '0;
  logic             pix_ready;
  logic [LTP:0]     time_val;
  logic [NS-1:0][LTP:0] spike_times;
  logic             training;
  logic             frame_done;
  logic             busy;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  int pend[$];
  int m_buf[NS];
  int m_act[NS];
  bit m_full, m_run, m_train, m_done;
  int m_t;

  spike_train_encoder #(
    .NUM_SPIKES(NS), .TIME_PERIOD(TP), .LOG_TIME_PERIOD(LTP),
    .PIX_BITS(PB), .THRESH(TH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .train_en(train_en),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .time_val(time_val), .spike_times(spike_times), .training(training),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int enc(int p);
    if (p < TH) return NO;
    return ((2**PB - 1) - p) / (2**(PB - LTP));
  endfunction

  function automatic bit model_ready();
`ifdef SPIKE_ENC_DBUF_EN
    return !m_full;
`else
    return !m_full && !m_run;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit acc, last, start;
    acc = pix_valid && model_ready();
    if (rst) begin
      pend.delete();
      m_full = 0; m_run = 0; m_t = TP - 1; m_train = 0; m_done = 0;
      for (int i = 0; i < NS; i++) m_act[i] = NO;
      return;
    end
    last  = m_run && (m_t == TP - 1);
    start = m_full && enable && (!m_run || last);
    m_done = m_run && (m_t == TP - 2);
    if (start) begin
      m_run = 1; m_t = 0; m_act = m_buf; m_train = train_en; m_full = 0;
    end else if (last) begin
      m_run = 0; m_t = TP - 1; m_train = 0;
      for (int i = 0; i < NS; i++) m_act[i] = NO;
    end else if (m_run) begin
      m_t++;
    end
    if (acc) begin
      pend.push_back(enc(int'(pix_data)));
      if (pend.size() == NS) begin
        for (int i = 0; i < NS; i++) m_buf[i] = pend[i];
        m_full = 1;
        pend.delete();
      end
    end
  endtask

  task automatic check_all();
    logic [NS*(LTP+1)-1:0] exp_st;
    for (int i = 0; i < NS; i++) exp_st[i*(LTP+1) +: LTP+1] = (LTP+1)'(m_act[i]);
    chk("time_val", 32'(time_val), 32'(m_t));
    chk("spike_times", 32'(spike_times), 32'(exp_st));
    chk("training", 32'(training), 32'(m_train));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("busy", 32'(busy), 32'(m_run));
    chk("pix_ready", 32'(pix_ready), 32'(model_ready()));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(bit v, int d, bit en, bit te);
    pix_valid = v; pix_data = PB'(d); enable = en; train_en = te;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; pix_valid = 1'b0;
    cycle();
    chk("rst_time_val", 32'(time_val), 32'(TP - 1));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(pix_ready), 32'd1);
    rst = 1'b0;
  endtask

  initial begin : main
    int cnt;
    int bound;

    // reset state
    do_reset();
    chk("rst_spikes", 32'(spike_times), 32'h8888);

    // basic frame: 255, 100, 16, 0
    drive(1, 255, 1, 0);
    drive(1, 100, 1, 0);
    drive(1, 16, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("lat_t0", 32'(time_val), 32'd0);
    chk("frame0_st", 32'(spike_times), 32'h8740);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0);
    chk("idle_t7", 32'(time_val), 32'd7);

    // training latched at start; mid-frame toggles ignored
    drive(1, 255, 1, 1);
    drive(1, 100, 1, 1);
    drive(1, 16, 1, 1);
    drive(1, 0, 1, 1);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 1, (i == 0) ? 1'b1 : 1'($urandom_range(1)));
      if (training) cnt++;
    end
    chk("train_cnt", 32'(cnt), 32'd8);

    // continuous streaming
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1, int'($urandom_range(255)), 1, 0);
      if (busy && pix_ready) cnt++;
    end
`ifdef SPIKE_ENC_DBUF_EN
    chk("ready_in_run", 32'(cnt > 0), 32'd1);
`else
    chk("ready_in_run", 32'(cnt), 32'd0);
`endif
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 0);
    do_reset();

    // enable low with full buffer, then raise
    for (int i = 0; i < NS; i++) drive(1, int'($urandom_range(255)), 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
    chk("hold_ready", 32'(pix_ready), 32'd0);
    chk("hold_busy", 32'(busy), 32'd0);
    drive(0, 0, 1, 0);
    chk("en_busy", 32'(busy), 32'd1);
    chk("en_t0", 32'(time_val), 32'd0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0);

    // reset mid-frame with a partial load
    for (int i = 0; i < NS; i++) drive(1, int'($urandom_range(255)), 1, 0);
    bound = 0;
    while (!(m_run && m_t == 3) && bound < 30) begin
      drive(pend.size() < 2 && m_run && m_t >= 1, int'($urandom_range(255)), 1, 0);
      bound++;
    end
    chk("reach_t3", 32'(bound < 30), 32'd1);
    do_reset();
    chk("rst_mid_spikes", 32'(spike_times), 32'h8888);
    for (int i = 0; i < 3; i++) drive(1, int'($urandom_range(255)), 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0);
    chk("partial_idle", 32'(busy), 32'd0);
    drive(1, 200, 1, 0);
    drive(0, 0, 1, 0);
    chk("fresh_run", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0);

    // threshold boundary: 15 -> no spike, 16 -> time 7
    do_reset();
    drive(1, 15, 1, 0);
    drive(1, 16, 1, 0);
    drive(1, 200, 1, 0);
    drive(1, 40, 1, 0);
    drive(0, 0, 1, 0);
    chk("thresh_vec", 32'(spike_times), 32'h6178);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(1)), int'($urandom_range(255)),
            $urandom_range(7) != 0, 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
